// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM duty controller and its button front end.
// PWM_AUTO_REPEAT_EN (optional) enables button auto-repeat in pwm_btn_debounce.
package pwm_ctrl_pkg;

  localparam int DEBOUNCE_CYCLES = 4;
  localparam int STEPS           = 10;
  localparam int RESET_DUTY      = 5;
  localparam int REPEAT_CYCLES   = 8;
  localparam int STEP_W          = $clog2(STEPS + 1);

  // FSM encoding kept as plain constants so it can be probed as a bare vector.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_ARMED = 1'b1;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_INC  = 2'd1,
    CMD_DEC  = 2'd2
  } cmd_e;

endpackage

// File: rtl/pwm_duty_controller_if.sv
// Pin-side bundle of the duty controller: raw buttons and period pulse in, duty state out.
// Handshake: no valid/ready; period_start is a 1-cycle pulse, duty_update a 1-cycle strobe.
interface pwm_duty_controller_if;
  import pwm_ctrl_pkg::*;

  logic              inc_btn;
  logic              dec_btn;
  logic              period_start;
  logic [STEP_W-1:0] duty_step;
  logic              duty_update;
  logic              at_max;
  logic              at_min;

  modport master (
    output inc_btn, dec_btn, period_start,
    input  duty_step, duty_update, at_max, at_min
  );

  modport slave (
    input  inc_btn, dec_btn, period_start,
    output duty_step, duty_update, at_max, at_min
  );
endinterface

// File: rtl/pwm_btn_debounce.sv
// One button: 2-flop synchroniser, debounce counter and press-event pulse.
// With PWM_AUTO_REPEAT_EN a held button re-fires every REPEAT_CYCLES cycles.
module pwm_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic evt_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  // Counter only runs while the synced level disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (int'(cnt_q) == DEBOUNCE_CYCLES - 1) level_d = sync2_q;
      else                                    cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  assign rise = level_d & ~level_q;

`ifdef PWM_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_fire;

  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (level_q && level_d) begin
      if (int'(rep_q) == REPEAT_CYCLES - 1) rep_fire = 1'b1;
      else                                  rep_d    = rep_q + REP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end

  assign evt_d = rise | rep_fire;
`else
  assign evt_d = rise;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign evt_o = evt_q;
endmodule

// File: rtl/pwm_duty_controller.sv
// Duty-step sequencer: turns debounced presses into +/-1 commands committed on PWM period boundaries.
// PWM_AUTO_REPEAT_EN (optional) is forwarded to both button instances.
module pwm_duty_controller
  import pwm_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  pwm_duty_controller_if.slave bus,
  output state_t               dbg_state_o
);
  logic              inc_evt, dec_evt;
  state_t            state_q, state_d;
  cmd_e              pend_q, pend_d;
  logic [STEP_W-1:0] duty_q, duty_d;
  logic              upd_q, upd_d;
  logic              one_evt, both_evt;
  cmd_e              new_cmd;

  pwm_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_inc (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.inc_btn), .evt_o(inc_evt)
  );

  pwm_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dec (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.dec_btn), .evt_o(dec_evt)
  );

  assign one_evt  = inc_evt ^ dec_evt;
  assign both_evt = inc_evt & dec_evt;
  assign new_cmd  = inc_evt ? CMD_INC : CMD_DEC;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    duty_d  = duty_q;
    upd_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (one_evt) begin
          pend_d  = new_cmd;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (bus.period_start) begin
          if (pend_q == CMD_INC && int'(duty_q) < STEPS) begin
            duty_d = duty_q + STEP_W'(1);
            upd_d  = 1'b1;
          end else if (pend_q == CMD_DEC && duty_q != '0) begin
            duty_d = duty_q - STEP_W'(1);
            upd_d  = 1'b1;
          end
          state_d = ST_IDLE;
          pend_d  = CMD_NONE;
          // A press landing on the boundary becomes the next period's command.
          if (one_evt) begin
            pend_d  = new_cmd;
            state_d = ST_ARMED;
          end
        end else if (both_evt) begin
          pend_d  = CMD_NONE;
          state_d = ST_IDLE;
        end else if (one_evt) begin
          pend_d = new_cmd;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = CMD_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= CMD_NONE;
      duty_q  <= STEP_W'(RESET_DUTY);
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      duty_q  <= duty_d;
      upd_q   <= upd_d;
    end
  end

  assign bus.duty_step   = duty_q;
  assign bus.duty_update = upd_q;
  assign bus.at_max      = (int'(duty_q) == STEPS);
  assign bus.at_min      = (duty_q == '0);
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_pwm_duty_controller.sv
// Directed bench for pwm_duty_controller; period_start pulses every 10 cycles.
// The auto-repeat step runs only when PWM_AUTO_REPEAT_EN is defined.
module tb_pwm_duty_controller;
  import pwm_ctrl_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     tests;
  int     fails;
  int     upd_total;
  int     upd_mark;
  int     pcnt;
  bit     synced;

  pwm_duty_controller_if pif ();

  pwm_duty_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (pif.slave),
    .dbg_state_o(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running period generator: one pulse every 10 cycles.
  initial begin
    pcnt = 0;
    pif.period_start = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pcnt = (pcnt == 9) ? 0 : pcnt + 1;
      pif.period_start = (pcnt == 0);
    end
  end

  initial begin
    upd_total = 0;
    forever begin
      @(negedge clk);
      if (pif.duty_update === 1'b1) upd_total++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press for hold cycles, then leave enough time to release and commit.
  task automatic press(input bit inc, input bit dec, input int hold);
    pif.inc_btn = inc;
    pif.dec_btn = dec;
    idle(hold);
    pif.inc_btn = 1'b0;
    pif.dec_btn = 1'b0;
    idle(25);
  endtask

  // Leaves the bench at posedge+1 of the cycle right after a period_start pulse.
  task automatic sync_period(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pif.period_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    pif.inc_btn = 1'b0;
    pif.dec_btn = 1'b0;

    // 1. reset values
    idle(3);
    check("rst_duty", int'(pif.duty_step), 5);
    check("rst_update", int'(pif.duty_update), 0);
    check("rst_at_max", int'(pif.at_max), 0);
    check("rst_at_min", int'(pif.at_min), 0);
    check("rst_state", int'(dbg_state), 0);
    rst_n = 1'b1;
    idle(5);

    // 2. single clean press
    upd_mark = upd_total;
    press(1'b1, 1'b0, 20);
    check("press_duty", int'(pif.duty_step), 6);
    check("press_updates", upd_total - upd_mark, 1);
    check("press_state", int'(dbg_state), 0);

    // 3. short glitch is filtered
    upd_mark = upd_total;
    press(1'b1, 1'b0, 3);
    check("glitch_duty", int'(pif.duty_step), 6);
    check("glitch_updates", upd_total - upd_mark, 0);

    // 4. climb to the top, then one press past saturation
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0, 10);
      check("inc_step", int'(pif.duty_step), 7 + i);
    end
    check("at_max", int'(pif.at_max), 1);
    upd_mark = upd_total;
    press(1'b1, 1'b0, 10);
    check("sat_max_duty", int'(pif.duty_step), 10);
    check("sat_max_updates", upd_total - upd_mark, 0);

    // 4. mirror: down to zero, then one past
    for (int i = 0; i < 10; i++) begin
      press(1'b0, 1'b1, 10);
      check("dec_step", int'(pif.duty_step), 9 - i);
    end
    check("at_min", int'(pif.at_min), 1);
    check("at_max_clear", int'(pif.at_max), 0);
    upd_mark = upd_total;
    press(1'b0, 1'b1, 10);
    check("sat_min_duty", int'(pif.duty_step), 0);
    check("sat_min_updates", upd_total - upd_mark, 0);

    // 5a. simultaneous presses from duty 2 are ignored
    press(1'b1, 1'b0, 10);
    press(1'b1, 1'b0, 10);
    check("pre_sim_duty", int'(pif.duty_step), 2);
    upd_mark = upd_total;
    press(1'b1, 1'b1, 10);
    check("sim_duty", int'(pif.duty_step), 2);
    check("sim_updates", upd_total - upd_mark, 0);

    // 5b. dec then inc inside one period: inc wins
    sync_period(synced);
    check("sync_5b", int'(synced), 1);
    upd_mark = upd_total;
    pif.dec_btn = 1'b1;
    idle(2);
    pif.inc_btn = 1'b1;
    idle(10);
    pif.dec_btn = 1'b0;
    idle(2);
    pif.inc_btn = 1'b0;
    idle(25);
    check("latest_wins_duty", int'(pif.duty_step), 3);
    check("latest_wins_updates", upd_total - upd_mark, 1);

    // 6a. reset while ARMED drops the pending command
    sync_period(synced);
    check("sync_6a", int'(synced), 1);
    pif.inc_btn = 1'b1;
    idle(7);
    check("armed_before_rst", int'(dbg_state), 1);
    pif.inc_btn = 1'b0;
    rst_n = 1'b0;
    idle(2);
    check("mid_rst_duty", int'(pif.duty_step), 5);
    rst_n = 1'b1;
    upd_mark = upd_total;
    idle(25);
    check("post_rst_duty", int'(pif.duty_step), 5);
    check("post_rst_updates", upd_total - upd_mark, 0);
    check("post_rst_state", int'(dbg_state), 0);

`ifdef PWM_AUTO_REPEAT_EN
    // 6b. held button auto-repeats, at most one step per period
    upd_mark = upd_total;
    press(1'b1, 1'b0, 40);
    check("repeat_multi", int'((upd_total - upd_mark) >= 3), 1);
    check("repeat_duty", int'(pif.duty_step), 5 + (upd_total - upd_mark));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
